// File: rtl/pkt_serializer.sv
// Packet-to-beat serializer: latches one PACKET_SIZE-bit packet and streams it
// out LSB beat first over a valid/ready beat interface.
module pkt_serializer #(
    parameter int unsigned PACKET_SIZE = 114,
    parameter int unsigned BEAT_WIDTH  = 32,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            pkt_valid_i,
    input  logic [PACKET_SIZE-1:0]          pkt_data_i,
    output logic                            pkt_ready_o,
    output logic                            beat_valid_o,
    output logic [BEAT_WIDTH-1:0]           beat_data_o,
    output logic [$clog2(BEAT_WIDTH+1)-1:0] beat_nbits_o,
    output logic                            beat_last_o,
    input  logic                            beat_ready_i,
    input  logic                            flush_i,
    output logic                            busy_o,
    output logic                            pkt_done_o,
    output logic [CNT_W-1:0]                pkt_cnt_o
);

    localparam int unsigned NBEATS = (PACKET_SIZE + BEAT_WIDTH - 1) / BEAT_WIDTH;
    localparam int unsigned IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int unsigned NB_W   = $clog2(BEAT_WIDTH + 1);
    localparam int unsigned PAD_W  = NBEATS * BEAT_WIDTH;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NBEATS - 1);
    localparam logic [NB_W-1:0]  FULL_NBITS = NB_W'(BEAT_WIDTH);
    localparam logic [NB_W-1:0]  LAST_NBITS = NB_W'(PACKET_SIZE - (NBEATS - 1) * BEAT_WIDTH);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                              state;
    logic [NBEATS-1:0][BEAT_WIDTH-1:0]   shadow;
    logic [NBEATS-1:0][BEAT_WIDTH-1:0]   pkt_beats;
    logic [PAD_W-1:0]                    pkt_pad;
    logic [IDX_W-1:0]                    idx;
    logic [IDX_W-1:0]                    idx_nxt;

    // Zero-extend the packet to a whole number of beats so the tail beat reads 0 above PACKET_SIZE.
    always_comb begin
        pkt_pad                  = '0;
        pkt_pad[PACKET_SIZE-1:0] = pkt_data_i;
        pkt_beats                = pkt_pad;
        idx_nxt                  = idx + IDX_W'(1);
    end

    assign pkt_ready_o = (state == IDLE);

    function automatic logic [NB_W-1:0] nbits_for(input logic [IDX_W-1:0] i);
        return (i == LAST_IDX) ? LAST_NBITS : FULL_NBITS;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            shadow       <= '0;
            idx          <= '0;
            beat_valid_o <= 1'b0;
            beat_data_o  <= '0;
            beat_nbits_o <= '0;
            beat_last_o  <= 1'b0;
            busy_o       <= 1'b0;
            pkt_done_o   <= 1'b0;
            pkt_cnt_o    <= '0;
        end else begin
            pkt_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    // flush_i has no effect here; a pending packet is still taken.
                    if (pkt_valid_i) begin
                        shadow       <= pkt_beats;
                        idx          <= '0;
                        state        <= SEND;
                        busy_o       <= 1'b1;
                        beat_valid_o <= 1'b1;
                        beat_data_o  <= pkt_beats[0];
                        beat_nbits_o <= nbits_for('0);
                        beat_last_o  <= (LAST_IDX == '0);
                    end
                end
                SEND: begin
                    if (flush_i) begin
                        // Abort wins over a same-cycle last-beat handshake.
                        state        <= IDLE;
                        idx          <= '0;
                        busy_o       <= 1'b0;
                        beat_valid_o <= 1'b0;
                        beat_data_o  <= '0;
                        beat_nbits_o <= '0;
                        beat_last_o  <= 1'b0;
                    end else if (beat_ready_i) begin
                        if (idx == LAST_IDX) begin
                            state        <= IDLE;
                            idx          <= '0;
                            busy_o       <= 1'b0;
                            beat_valid_o <= 1'b0;
                            beat_data_o  <= '0;
                            beat_nbits_o <= '0;
                            beat_last_o  <= 1'b0;
                            pkt_done_o   <= 1'b1;
                            pkt_cnt_o    <= pkt_cnt_o + CNT_W'(1);
                        end else begin
                            idx          <= idx_nxt;
                            beat_data_o  <= shadow[idx_nxt];
                            beat_nbits_o <= nbits_for(idx_nxt);
                            beat_last_o  <= (idx_nxt == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_serializer.sv
// Directed bench for pkt_serializer: a beat-list model of the serializer is
// compared against the DUT every cycle, plus hand-computed literal checks.
module tb_pkt_serializer;

    localparam int PS  = 114;
    localparam int BW  = 32;
    localparam int NB  = (PS + BW - 1) / BW;
    localparam int NBW = $clog2(BW + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, pkt_valid, beat_ready, flush;
    logic [PS-1:0] pkt_data;

    logic           pkt_ready, beat_valid, beat_last, busy, pkt_done;
    logic [BW-1:0]  beat_data;
    logic [NBW-1:0] beat_nbits;
    logic [15:0]    pkt_cnt;

    logic           d2_pkt_ready, d2_beat_valid, d2_beat_last, d2_busy, d2_pkt_done;
    logic [BW-1:0]  d2_beat_data;
    logic [NBW-1:0] d2_beat_nbits;
    logic [1:0]     d2_pkt_cnt;

    pkt_serializer #(.PACKET_SIZE(PS), .BEAT_WIDTH(BW), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .pkt_valid_i(pkt_valid), .pkt_data_i(pkt_data),
        .pkt_ready_o(pkt_ready), .beat_valid_o(beat_valid), .beat_data_o(beat_data),
        .beat_nbits_o(beat_nbits), .beat_last_o(beat_last), .beat_ready_i(beat_ready),
        .flush_i(flush), .busy_o(busy), .pkt_done_o(pkt_done), .pkt_cnt_o(pkt_cnt)
    );

    pkt_serializer #(.PACKET_SIZE(PS), .BEAT_WIDTH(BW), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .pkt_valid_i(pkt_valid), .pkt_data_i(pkt_data),
        .pkt_ready_o(d2_pkt_ready), .beat_valid_o(d2_beat_valid), .beat_data_o(d2_beat_data),
        .beat_nbits_o(d2_beat_nbits), .beat_last_o(d2_beat_last), .beat_ready_i(beat_ready),
        .flush_i(flush), .busy_o(d2_busy), .pkt_done_o(d2_pkt_done), .pkt_cnt_o(d2_pkt_cnt)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: a packet in flight is a list of beats plus the position of the beat on offer.
    bit            m_busy = 0;
    bit            m_done = 0;
    int            m_idx  = 0;
    int unsigned   m_cnt  = 0;
    logic [BW-1:0] m_beats [NB];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        logic [127:0] t;
        if (rst) begin
            m_busy = 0; m_done = 0; m_idx = 0; m_cnt = 0;
        end else begin
            m_done = 0;
            if (!m_busy) begin
                if (pkt_valid) begin
                    t = 128'(pkt_data);
                    for (int k = 0; k < NB; k++) begin
                        m_beats[k] = t[BW-1:0];
                        t = t >> BW;
                    end
                    m_idx  = 0;
                    m_busy = 1;
                end
            end else if (flush) begin
                m_busy = 0; m_idx = 0;
            end else if (beat_ready) begin
                if (m_idx == NB - 1) begin
                    m_busy = 0; m_idx = 0; m_done = 1;
                    m_cnt  = (m_cnt + 1) % 65536;
                end else begin
                    m_idx++;
                end
            end
        end
    endtask

    task automatic compare();
        chk("pkt_ready", 128'(pkt_ready), 128'(!m_busy));
        chk("beat_valid", 128'(beat_valid), 128'(m_busy));
        chk("busy", 128'(busy), 128'(m_busy));
        chk("pkt_done", 128'(pkt_done), 128'(m_done));
        chk("pkt_cnt", 128'(pkt_cnt), 128'(m_cnt));
        chk("d2_pkt_cnt", 128'(d2_pkt_cnt), 128'(m_cnt % 4));
        if (m_busy) begin
            chk("beat_data", 128'(beat_data), 128'(m_beats[m_idx]));
            chk("beat_nbits", 128'(beat_nbits),
                128'((m_idx == NB - 1) ? PS - (NB - 1) * BW : BW));
            chk("beat_last", 128'(beat_last), 128'(m_idx == NB - 1));
        end
    endtask

    task automatic tick();
        model_update();
        @(negedge clk);
        compare();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (m_busy && n < 40) begin
            tick();
            n++;
        end
        chk(tag, 128'(m_busy), 128'(0));
    endtask

    function automatic logic [PS-1:0] rand_pkt();
        return PS'({$urandom, $urandom, $urandom, $urandom});
    endfunction

    logic [PS-1:0] pat, pa, pb;
    int            exp6 [5] = '{1, 2, 3, 0, 1};

    initial begin
        rst = 1; pkt_valid = 0; pkt_data = '0; beat_ready = 1; flush = 0;
        pat = '0;
        for (int i = 0; i < PS; i += 8) pat[i] = 1'b1;

        // 1: reset
        tick(); tick();
        chk("rst_ready", 128'(pkt_ready), 128'(1));
        chk("rst_valid", 128'(beat_valid), 128'(0));
        chk("rst_cnt", 128'(pkt_cnt), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        rst = 0;

        // 2: basic packet
        pkt_data = pat; pkt_valid = 1;
        tick();
        pkt_valid = 0;
        chk("t2_beat0", 128'(beat_data), 128'h01010101);
        chk("t2_nbits0", 128'(beat_nbits), 128'(32));
        for (int n = 0; n < 10 && m_busy; n++) begin
            if (m_idx == NB - 1) begin
                chk("t2_last_data", 128'(beat_data), 128'h00010101);
                chk("t2_last_nbits", 128'(beat_nbits), 128'(18));
                chk("t2_last_flag", 128'(beat_last), 128'(1));
            end
            tick();
        end
        chk("t2_done", 128'(pkt_done), 128'(1));
        chk("t2_cnt", 128'(pkt_cnt), 128'(1));
        tick();
        chk("t2_done_pulse", 128'(pkt_done), 128'(0));

        // 3: stall on beat 1
        pkt_valid = 1;
        tick();
        pkt_valid = 0;
        tick();
        beat_ready = 0;
        repeat (3) tick();
        chk("t3_held", 128'(beat_data), 128'h01010101);
        beat_ready = 1;
        drain("t3_drain");
        chk("t3_cnt", 128'(pkt_cnt), 128'(2));

        // 4: flush on beat 2, flush ignored in IDLE, flush beats last handshake
        pa = rand_pkt();
        pkt_data = pa; pkt_valid = 1;
        tick();
        pkt_valid = 0;
        tick(); tick();
        flush = 1;
        tick();
        flush = 0;
        chk("t4_flush_valid", 128'(beat_valid), 128'(0));
        chk("t4_flush_cnt", 128'(pkt_cnt), 128'(2));
        pb = rand_pkt();
        pkt_data = pb; pkt_valid = 1; flush = 1;
        tick();
        pkt_valid = 0; flush = 0;
        chk("t4_restart_beat0", 128'(beat_data), 128'(pb[31:0]));
        drain("t4_drain");
        chk("t4_cnt", 128'(pkt_cnt), 128'(3));
        pkt_data = pa; pkt_valid = 1;
        tick();
        pkt_valid = 0;
        for (int n = 0; n < 10 && m_idx != NB - 1; n++) tick();
        flush = 1;
        tick();
        flush = 0;
        chk("t4_lastflush_done", 128'(pkt_done), 128'(0));
        chk("t4_lastflush_cnt", 128'(pkt_cnt), 128'(3));

        // 5: back-to-back with pkt_valid held high
        rst = 1; tick(); rst = 0;
        pa = rand_pkt(); pb = rand_pkt();
        pkt_data = pa; pkt_valid = 1;
        tick();
        pkt_data = pb;
        for (int n = 0; n < 10 && m_idx != NB - 1; n++) tick();
        tick();
        chk("t5_gap_valid", 128'(beat_valid), 128'(0));
        chk("t5_gap_done", 128'(pkt_done), 128'(1));
        tick();
        pkt_valid = 0;
        chk("t5_b_valid", 128'(beat_valid), 128'(1));
        chk("t5_b_beat0", 128'(beat_data), 128'(pb[31:0]));
        drain("t5_drain");
        chk("t5_cnt", 128'(pkt_cnt), 128'(2));

        // 6: 2-bit counter wrap
        rst = 1; tick(); rst = 0;
        for (int p = 0; p < 5; p++) begin
            pkt_data = rand_pkt(); pkt_valid = 1;
            tick();
            pkt_valid = 0;
            drain("t6_drain");
            chk("t6_cnt", 128'(d2_pkt_cnt), 128'(exp6[p]));
        end
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, miscompares=%0d", miscompares);
        $fatal(1, "watchdog");
    end

endmodule
